// File: rtl/lock_key_loader.sv
// Serial key loader for the mux-locked c432 netlist: it receives framed serial keys,
// checks even parity, latches good keys, and rate-limits repeated bad frames with a lockout.
module lock_key_loader #(
   parameter int unsigned KEY_W    = 4,
   parameter int unsigned MAX_FAIL = 3,
   parameter int unsigned LOCK_CYC = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             key_bit,
   input  logic             key_valid,
   output logic             key_ready,
   input  logic             key_clear,
   output logic [KEY_W-1:0] key_out,
   output logic             key_loaded,
   output logic             key_err,
   output logic             locked_out
);

   localparam int unsigned CNT_W = $clog2(KEY_W + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_CHECK,
      ST_LOCKOUT
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [KEY_W-1:0]   shreg_q, shreg_d;
   logic               parity_q, parity_d;
   logic [3:0]         fail_cnt_q, fail_cnt_d;
   logic [15:0]        lock_cnt_q, lock_cnt_d;
   logic [KEY_W-1:0]   key_out_q, key_out_d;
   logic               key_loaded_q, key_loaded_d;
   logic               key_err_q, key_err_d;
   logic               transfer;

   assign key_ready  = (state_q == ST_IDLE) || (state_q == ST_SHIFT);
   assign locked_out = (state_q == ST_LOCKOUT);
   assign key_out    = key_out_q;
   assign key_loaded = key_loaded_q;
   assign key_err    = key_err_q;
   assign transfer   = key_valid && key_ready;

   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shreg_d      = shreg_q;
      parity_d     = parity_q;
      fail_cnt_d   = fail_cnt_q;
      lock_cnt_d   = lock_cnt_q;
      key_out_d    = key_out_q;
      key_loaded_d = key_loaded_q;
      key_err_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (transfer) begin
               shreg_d[0] = key_bit;
               parity_d   = key_bit;
               bit_cnt_d  = CNT_W'(1);
               state_d    = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (transfer) begin
               parity_d = parity_q ^ key_bit;
               // Once all data bits are in, this transfer is the parity bit.
               if (bit_cnt_q == CNT_W'(KEY_W)) begin
                  state_d = ST_CHECK;
               end else begin
                  for (int unsigned i = 0; i < KEY_W; i++) begin
                     if (32'(bit_cnt_q) == i) shreg_d[i] = key_bit;
                  end
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
               end
            end
         end
         ST_CHECK: begin
            bit_cnt_d = '0;
            state_d   = ST_IDLE;
            if (!parity_q) begin
               key_out_d    = shreg_q;
               key_loaded_d = 1'b1;
               fail_cnt_d   = '0;
            end else begin
               key_err_d  = 1'b1;
               fail_cnt_d = fail_cnt_q + 4'd1;
               if (fail_cnt_q + 4'd1 == 4'(MAX_FAIL)) begin
                  state_d    = ST_LOCKOUT;
                  lock_cnt_d = 16'(LOCK_CYC - 1);
               end
            end
         end
         ST_LOCKOUT: begin
            if (lock_cnt_q == '0) begin
               fail_cnt_d = '0;
               state_d    = ST_IDLE;
            end else begin
               lock_cnt_d = lock_cnt_q - 16'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Clear overrides everything except the lockout timer.
      if (key_clear) begin
         key_out_d    = '0;
         key_loaded_d = 1'b0;
         if (state_q != ST_LOCKOUT) begin
            state_d    = ST_IDLE;
            bit_cnt_d  = '0;
            key_err_d  = 1'b0;
            fail_cnt_d = fail_cnt_q;
            lock_cnt_d = lock_cnt_q;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         bit_cnt_q    <= '0;
         shreg_q      <= '0;
         parity_q     <= 1'b0;
         fail_cnt_q   <= '0;
         lock_cnt_q   <= '0;
         key_out_q    <= '0;
         key_loaded_q <= 1'b0;
         key_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shreg_q      <= shreg_d;
         parity_q     <= parity_d;
         fail_cnt_q   <= fail_cnt_d;
         lock_cnt_q   <= lock_cnt_d;
         key_out_q    <= key_out_d;
         key_loaded_q <= key_loaded_d;
         key_err_q    <= key_err_d;
      end
   end

endmodule

// File: tb/tb_lock_key_loader.sv
// Directed bench for lock_key_loader: per-cycle vector table plus hand sequences
// for stalled frames and asynchronous reset mid-frame / mid-lockout.
module tb_lock_key_loader;

   logic       clk = 1'b0;
   logic       rst;
   logic       key_bit;
   logic       key_valid;
   logic       key_ready;
   logic       key_clear;
   logic [3:0] key_out;
   logic       key_loaded;
   logic       key_err;
   logic       locked_out;

   int unsigned errors = 0;
   int unsigned checks = 0;

   lock_key_loader #(.KEY_W(4), .MAX_FAIL(3), .LOCK_CYC(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .key_bit    (key_bit),
      .key_valid  (key_valid),
      .key_ready  (key_ready),
      .key_clear  (key_clear),
      .key_out    (key_out),
      .key_loaded (key_loaded),
      .key_err    (key_err),
      .locked_out (locked_out)
   );

   always #5 clk = ~clk;

   // Inputs applied during a cycle, and outputs expected during that same cycle.
   typedef struct {
      logic       v;
      logic       b;
      logic       c;
      logic       rdy;
      logic [3:0] out;
      logic       ld;
      logic       err;
      logic       lk;
   } vec_t;

   vec_t vecs[$];

   task automatic row(input logic v, input logic b, input logic c, input logic rdy,
                      input logic [3:0] out, input logic ld, input logic err, input logic lk);
      vec_t r;
      r.v = v; r.b = b; r.c = c; r.rdy = rdy; r.out = out; r.ld = ld; r.err = err; r.lk = lk;
      vecs.push_back(r);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_all(input string tag, input logic rdy, input logic [3:0] out,
                          input logic ld, input logic err, input logic lk);
      chk({tag, ".key_ready"},  32'(key_ready),  32'(rdy));
      chk({tag, ".key_out"},    32'(key_out),    32'(out));
      chk({tag, ".key_loaded"}, 32'(key_loaded), 32'(ld));
      chk({tag, ".key_err"},    32'(key_err),    32'(err));
      chk({tag, ".locked_out"}, 32'(locked_out), 32'(lk));
   endtask

   // Sends bits[0..4] (data LSB first, then parity) with random 0..max_gap idle cycles
   // before each bit; returns at the CHECK cycle with key_valid low.
   task automatic send_frame(input logic [4:0] bits, input int unsigned max_gap);
      for (int i = 0; i < 5; i++) begin
         int unsigned gap = $urandom_range(max_gap, 0);
         for (int unsigned g = 0; g < gap; g++) begin
            key_valid = 1'b0;
            @(negedge clk);
         end
         key_valid = 1'b1;
         key_bit   = bits[i];
         @(negedge clk);
      end
      key_valid = 1'b0;
      key_bit   = 1'b0;
   endtask

   initial begin
      rst = 1'b1; key_bit = 1'b0; key_valid = 1'b0; key_clear = 1'b0;
      #1;
      chk_all("reset", 1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      //  v  b  c   rdy out  ld err lk
      // good key 0,1,1,0 parity 0 -> 4'b0110
      row(1, 0, 0,  1, 4'h0, 0, 0, 0);
      row(1, 1, 0,  1, 4'h0, 0, 0, 0);
      row(1, 1, 0,  1, 4'h0, 0, 0, 0);
      row(1, 0, 0,  1, 4'h0, 0, 0, 0);
      row(1, 0, 0,  1, 4'h0, 0, 0, 0);
      row(0, 0, 0,  0, 4'h0, 0, 0, 0);   // CHECK
      row(0, 0, 0,  1, 4'h6, 1, 0, 0);
      // bad frame 1: 1,1,1,0 parity 0
      row(1, 1, 0,  1, 4'h6, 1, 0, 0);
      row(1, 1, 0,  1, 4'h6, 1, 0, 0);
      row(1, 1, 0,  1, 4'h6, 1, 0, 0);
      row(1, 0, 0,  1, 4'h6, 1, 0, 0);
      row(1, 0, 0,  1, 4'h6, 1, 0, 0);
      row(0, 0, 0,  0, 4'h6, 1, 0, 0);   // CHECK
      row(0, 0, 0,  1, 4'h6, 1, 1, 0);   // err pulse, fail=1
      // bad frame 2: 1,0,0,0 parity 0
      row(1, 1, 0,  1, 4'h6, 1, 0, 0);
      row(1, 0, 0,  1, 4'h6, 1, 0, 0);
      row(1, 0, 0,  1, 4'h6, 1, 0, 0);
      row(1, 0, 0,  1, 4'h6, 1, 0, 0);
      row(1, 0, 0,  1, 4'h6, 1, 0, 0);
      row(0, 0, 0,  0, 4'h6, 1, 0, 0);
      row(0, 0, 0,  1, 4'h6, 1, 1, 0);   // fail=2
      // bad frame 3: 0,0,0,0 parity 1 -> lockout
      row(1, 0, 0,  1, 4'h6, 1, 0, 0);
      row(1, 0, 0,  1, 4'h6, 1, 0, 0);
      row(1, 0, 0,  1, 4'h6, 1, 0, 0);
      row(1, 0, 0,  1, 4'h6, 1, 0, 0);
      row(1, 1, 0,  1, 4'h6, 1, 0, 0);
      row(0, 0, 0,  0, 4'h6, 1, 0, 0);
      row(1, 1, 0,  0, 4'h6, 1, 1, 1);   // first lockout cycle, bits ignored
      for (int i = 1; i < 16; i++) row(1, 1, 0,  0, 4'h6, 1, 0, 1);
      // good frame 1,0,0,0 parity 1 -> 4'b0001
      row(1, 1, 0,  1, 4'h6, 1, 0, 0);
      row(1, 0, 0,  1, 4'h6, 1, 0, 0);
      row(1, 0, 0,  1, 4'h6, 1, 0, 0);
      row(1, 0, 0,  1, 4'h6, 1, 0, 0);
      row(1, 1, 0,  1, 4'h6, 1, 0, 0);
      row(0, 0, 0,  0, 4'h6, 1, 0, 0);
      row(0, 0, 0,  1, 4'h1, 1, 0, 0);
      // clear with 2nd bit; fresh frame 1,1,0,0 parity 0 -> 4'b0011
      row(1, 1, 0,  1, 4'h1, 1, 0, 0);
      row(1, 0, 1,  1, 4'h1, 1, 0, 0);
      row(1, 1, 0,  1, 4'h0, 0, 0, 0);
      row(1, 1, 0,  1, 4'h0, 0, 0, 0);
      row(1, 0, 0,  1, 4'h0, 0, 0, 0);
      row(1, 0, 0,  1, 4'h0, 0, 0, 0);
      row(1, 0, 0,  1, 4'h0, 0, 0, 0);
      row(0, 0, 0,  0, 4'h0, 0, 0, 0);
      row(0, 0, 0,  1, 4'h3, 1, 0, 0);
      // bad frame with clear during CHECK: no err, fail stays 0
      row(1, 1, 0,  1, 4'h3, 1, 0, 0);
      row(1, 1, 0,  1, 4'h3, 1, 0, 0);
      row(1, 1, 0,  1, 4'h3, 1, 0, 0);
      row(1, 0, 0,  1, 4'h3, 1, 0, 0);
      row(1, 0, 0,  1, 4'h3, 1, 0, 0);
      row(0, 0, 1,  0, 4'h3, 1, 0, 0);
      // two more bad frames must not reach lockout
      row(1, 1, 0,  1, 4'h0, 0, 0, 0);
      row(1, 0, 0,  1, 4'h0, 0, 0, 0);
      row(1, 0, 0,  1, 4'h0, 0, 0, 0);
      row(1, 0, 0,  1, 4'h0, 0, 0, 0);
      row(1, 0, 0,  1, 4'h0, 0, 0, 0);
      row(0, 0, 0,  0, 4'h0, 0, 0, 0);
      row(1, 1, 0,  1, 4'h0, 0, 1, 0);
      row(1, 0, 0,  1, 4'h0, 0, 0, 0);
      row(1, 0, 0,  1, 4'h0, 0, 0, 0);
      row(1, 0, 0,  1, 4'h0, 0, 0, 0);
      row(1, 0, 0,  1, 4'h0, 0, 0, 0);
      row(0, 0, 0,  0, 4'h0, 0, 0, 0);
      row(0, 0, 0,  1, 4'h0, 0, 1, 0);
      row(0, 0, 0,  1, 4'h0, 0, 0, 0);

      foreach (vecs[i]) begin
         @(negedge clk);
         key_valid = vecs[i].v;
         key_bit   = vecs[i].b;
         key_clear = vecs[i].c;
         #1;
         chk_all($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].out, vecs[i].ld,
                 vecs[i].err, vecs[i].lk);
      end
      @(negedge clk);
      key_valid = 1'b0; key_clear = 1'b0;

      // Stalled good frame 0,1,1,0 parity 0
      send_frame(5'b00110, 3);
      @(negedge clk);
      #1;
      chk_all("stall", 1'b1, 4'h6, 1'b1, 1'b0, 1'b0);

      // Async reset mid-frame
      @(negedge clk);
      send_frame(5'b00011, 0);
      @(negedge clk);
      key_valid = 1'b1; key_bit = 1'b1;
      #2 rst = 1'b1;
      #1;
      chk_all("rst_frame", 1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0; key_valid = 1'b0;

      // Async reset mid-lockout
      send_frame(5'b00001, 0);
      @(negedge clk);
      send_frame(5'b00001, 0);
      @(negedge clk);
      send_frame(5'b00001, 0);
      for (int i = 0; i < 4; i++) @(negedge clk);
      #1;
      chk("pre_rst.locked_out", 32'(locked_out), 32'd1);
      chk("pre_rst.key_ready",  32'(key_ready),  32'd0);
      #2 rst = 1'b1;
      #1;
      chk_all("rst_lock", 1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      // Good frame after reset: 1,0,0,0 parity 1
      send_frame(5'b10001, 1);
      @(negedge clk);
      #1;
      chk_all("post_rst", 1'b1, 4'h1, 1'b1, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
